// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store unit
package lsu_pkg;

  localparam int MEM_DEPTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_SB   = 2'b01;
  localparam logic [1:0] WE_SH   = 2'b10;
  localparam logic [1:0] WE_SW   = 2'b11;

  localparam logic [2:0] RE_LW  = 3'b000;
  localparam logic [2:0] RE_LB  = 3'b001;
  localparam logic [2:0] RE_LH  = 3'b010;
  localparam logic [2:0] RE_LBU = 3'b011;
  localparam logic [2:0] RE_LHU = 3'b100;

endpackage

// File: rtl/lsu_decode.sv
// rtl/lsu_decode.sv - access legality check and memory write/read code mapping
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        err,
  output logic [1:0]  we,
  output logic [2:0]  re
);

  always_comb begin
    err = 1'b0;
    we  = WE_NONE;
    re  = RE_LW;
    if (store) begin
      case (funct3)
        F3_B:    we = WE_SB;
        F3_H:    we = WE_SH;
        F3_W:    we = WE_SW;
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    re = RE_LB;
        F3_H:    re = RE_LH;
        F3_W:    re = RE_LW;
        F3_BU:   re = RE_LBU;
        F3_HU:   re = RE_LHU;
        default: err = 1'b1;
      endcase
    end
    // funct3[1:0] is the access size for every legal code
    if (funct3[1:0] == 2'b01 && addr[0] != 1'b0)
      err = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
      err = 1'b1;
    if (addr >= 32'(MEM_DEPTH))
      err = 1'b1;
    if (err)
      we = WE_NONE;
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - three-state load/store unit between pipeline and data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic [1:0]  mem_WE,
  output logic [2:0]  mem_RE,
  input  logic [31:0] mem_RD
);

  lsu_state_t  state, state_nxt;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        accept;

  logic        dec_store;
  logic [2:0]  dec_funct3;
  logic [31:0] dec_addr;
  logic        dec_err;
  logic [1:0]  dec_we;
  logic [2:0]  dec_re;

  assign accept = (state == IDLE) && req_valid;

  // One decoder: classifies the incoming request in IDLE, the held request afterwards
  assign dec_store  = (state == IDLE) ? req_store  : store_q;
  assign dec_funct3 = (state == IDLE) ? req_funct3 : funct3_q;
  assign dec_addr   = (state == IDLE) ? req_addr   : addr_q;

  lsu_decode #(.MEM_DEPTH(MEM_DEPTH)) u_decode (
    .store  (dec_store),
    .funct3 (dec_funct3),
    .addr   (dec_addr),
    .err    (dec_err),
    .we     (dec_we),
    .re     (dec_re)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = dec_err ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      store_q   <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      store_q   <= req_store;
      funct3_q  <= req_funct3;
      addr_q    <= req_addr;
      wdata_q   <= req_wdata;
      rsp_rdata <= 32'd0;
      rsp_err   <= dec_err;
    end else if (state == ACCESS) begin
      rsp_rdata <= store_q ? 32'd0 : mem_RD;
    end
  end

  // Write enable is gated by rst directly so a reset edge never commits a store
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    mem_A     = 32'd0;
    mem_WD    = 32'd0;
    mem_WE    = WE_NONE;
    mem_RE    = RE_LW;
    if (state == ACCESS) begin
      mem_A  = addr_q;
      mem_WD = wdata_q;
      mem_WE = rst ? dec_we : WE_NONE;
      mem_RE = dec_re;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [1:0]  mem_WE;
  logic [2:0]  mem_RE;
  logic [31:0] mem_RD;

  int checks = 0;
  int errors = 0;
  int we_cycles = 0;
  int anz_cycles = 0;
  int we_snap;
  int anz_snap;

  logic [31:0] tbmem [0:255];

  load_store_unit #(.MEM_DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RE     (mem_RE),
    .mem_RD     (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple memory: address 4 returns a fixed sign-extended byte pattern
  assign mem_RD = (mem_A == 32'd4) ? 32'hFFFF_FF80 : tbmem[mem_A[7:0]];

  always @(posedge clk) begin
    if (mem_WE != 2'b00) begin
      tbmem[mem_A[7:0]] <= mem_WD;
      we_cycles <= we_cycles + 1;
    end
    if (mem_A != 32'd0)
      anz_cycles <= anz_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request at the current falling edge; returns one cycle after the accept edge
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_mem_we", 32'(mem_WE), 32'd0);
    chk("reset_mem_a", mem_A, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // sw addr 8
    we_snap = we_cycles;
    do_req(1'b1, 3'b010, 32'd8, 32'hDEAD_BEEF);
    chk("sw_req_ready_busy", 32'(req_ready), 32'd0);
    chk("sw_mem_we", 32'(mem_WE), 32'd3);
    chk("sw_mem_a", mem_A, 32'd8);
    chk("sw_mem_wd", mem_WD, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sw_rsp_err", 32'(rsp_err), 32'd0);
    chk("sw_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    chk("sw_back_idle", 32'(req_ready), 32'd1);
    chk("sw_one_we_cycle", 32'(we_cycles - we_snap), 32'd1);
    chk("idle_mem_we", 32'(mem_WE), 32'd0);

    // lw addr 8
    do_req(1'b0, 3'b010, 32'd8, 32'd0);
    chk("lw_mem_re", 32'(mem_RE), 32'd0);
    chk("lw_mem_a", mem_A, 32'd8);
    chk("lw_mem_we", 32'(mem_WE), 32'd0);
    @(negedge clk);
    chk("lw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lw_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("lw_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);

    // lb addr 4
    do_req(1'b0, 3'b000, 32'd4, 32'd0);
    chk("lb_mem_re", 32'(mem_RE), 32'd1);
    chk("lb_mem_a", mem_A, 32'd4);
    @(negedge clk);
    chk("lb_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lb_rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
    @(negedge clk);

    // misaligned and out-of-range accesses skip ACCESS entirely
    we_snap = we_cycles;
    anz_snap = anz_cycles;
    do_req(1'b0, 3'b010, 32'd6, 32'd0);
    chk("lw6_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lw6_rsp_err", 32'(rsp_err), 32'd1);
    chk("lw6_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    do_req(1'b1, 3'b001, 32'd3, 32'h1234_5678);
    chk("sh3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sh3_rsp_err", 32'(rsp_err), 32'd1);
    chk("sh3_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    chk("sh3_no_write", 32'(we_cycles - we_snap), 32'd0);
    do_req(1'b0, 3'b010, 32'd256, 32'd0);
    chk("lw256_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lw256_rsp_err", 32'(rsp_err), 32'd1);
    @(negedge clk);
    do_req(1'b0, 3'b011, 32'd0, 32'd0);
    chk("f3_011_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("f3_011_rsp_err", 32'(rsp_err), 32'd1);
    @(negedge clk);
    chk("err_no_mem_addr", 32'(anz_cycles - anz_snap), 32'd0);
    chk("err_no_write", 32'(we_cycles - we_snap), 32'd0);

    // stalled response after an error clears the error flag
    rsp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'd8, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("stall_rsp_err", 32'(rsp_err), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_idle", 32'(rsp_valid), 32'd0);

    // reset during ACCESS of a store
    we_snap = we_cycles;
    do_req(1'b1, 3'b010, 32'd12, 32'h1234_5678);
    chk("rstacc_we_before", 32'(mem_WE), 32'd3);
    rst = 1'b0;
    #1;
    chk("rstacc_we_gated", 32'(mem_WE), 32'd0);
    @(negedge clk);
    chk("rstacc_no_write", 32'(we_cycles - we_snap), 32'd0);
    chk("rstacc_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstacc_idle", 32'(req_ready), 32'd1);
    chk("rstacc_rdata_clr", rsp_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstacc_still_no_rsp", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit data-memory entries; addresses >= MEM_DEPTH are out of range.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 SHALL have port req_valid  input  1  pipeline presents an access.
REQ-005 SHALL have port req_ready  output  1  unit can accept an access this cycle.
REQ-006 SHALL have port req_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RISC-V width code: load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw.
REQ-008 SHALL have port req_addr  input  32  memory address, passed unchanged to the memory index.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  pipeline consumes the response.
REQ-012 SHALL have port rsp_rdata  output  32  load result, already extended.
REQ-013 SHALL have port rsp_err  output  1  access rejected: misaligned, out of range, or illegal funct3.
REQ-014 SHALL have port mem_A  output  32  data-memory address.
REQ-015 SHALL have port mem_WD  output  32  data-memory write data.
REQ-016 SHALL have port mem_WE  output  2  write code: 00 none, 01 sb, 10 sh, 11 sw.
REQ-017 SHALL have port mem_RE  output  3  read code: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu.
REQ-018 SHALL have port mem_RD  input  32  combinational read data from memory.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL, on req_valid && req_ready, register store flag, funct3, addr and wdata, and classify the access.
REQ-021 SHALL flag an error when funct3 is illegal for the direction, when a halfword has addr[0] != 0, when a word has addr[1:0] != 0, or when addr >= MEM_DEPTH.
REQ-022 SHALL go IDLE -> ACCESS for a legal access and IDLE -> RESP with rsp_err = 1 for an errored access; an errored access SHALL never drive mem_WE != 00.
REQ-023 SHALL, in ACCESS, drive mem_A = registered addr, mem_WD = registered wdata, and mem_WE or mem_RE per the mapped code, for exactly one cycle.
REQ-024 SHALL hold mem_A = 0, mem_WD = 0, mem_WE = 00 and mem_RE = 000 outside ACCESS.
REQ-025 SHALL, at the end of ACCESS, capture mem_RD into rsp_rdata for loads and 0 for stores, then enter RESP.
REQ-026 SHALL hold rsp_valid = 1 and stable rsp_rdata/rsp_err in RESP until rsp_ready = 1, then return to IDLE.
REQ-027 SHALL give a load-to-use latency of 2 cycles from the accept edge to the first rsp_valid cycle, with a maximum throughput of one access per 3 cycles at rsp_ready = 1.
REQ-028 SHALL clear rsp_err on every newly accepted access.
REQ-029 SHALL gate mem_WE to 00 combinationally whenever rst = 0, so that no store commits on a reset edge.

Reset
REQ-030 SHALL, on posedge clk with rst = 0, enter IDLE and clear all registers: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_* = 0.
REQ-031 SHALL abandon an in-flight access on reset mid-operation without producing a response.

Structure
REQ-032 SHALL place the WE/RE code constants, funct3 constants, FSM state typedef and MEM_DEPTH default in a shared package, lsu_pkg.
REQ-033 SHALL implement access classification (legality plus WE/RE mapping) as one combinational sub-module, lsu_decode.

Verification
REQ-034 SHALL cover: sw addr 8, wdata 0xDEADBEEF -> exactly one ACCESS cycle with mem_WE = 11, mem_A = 8; then lw addr 8 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-035 SHALL cover: lb addr 4 with mem_RD = 0xFFFFFF80 -> mem_RE = 001, rsp_rdata = 0xFFFFFF80 two cycles after accept.
REQ-036 SHALL cover: lw addr 6 or sh addr 3 -> rsp_err = 1, mem_WE = 00 throughout, rsp_rdata = 0.
REQ-037 SHALL cover: lw addr 256 or load funct3 = 011 -> rsp_err = 1, no ACCESS state.
REQ-038 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout.
REQ-039 SHALL cover: rst = 0 asserted during ACCESS of sw -> mem_WE = 00 that cycle, no rsp_valid, IDLE next cycle.
